load_align_unit: RTL

Sequential load-data alignment unit between the CPU memory stage and a variable-latency word-addressed data memory. It accepts a byte-addressed load request and issues one or two word reads. It then extracts the addressed byte, halfword or word in big-endian order, sign- or zero-extends the result, and returns it over a valid/ready handshake. Unlike the combinational load mask, it tracks request state, tolerates memory latency and backpressure, and can service loads that cross a word boundary.

---
 rtl/load_align_unit_if.sv | 44 ++++
 rtl/load_align_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/load_align_unit_if.sv
// load_align_unit_if: bundles the load request, word-memory read and
// response handshakes of the load alignment unit.
// slave  : view taken by load_align_unit
// master : view taken by the surrounding CPU/memory environment
interface load_align_unit_if #(
    parameter int ADDR_WIDTH = 32
) ();
    // Request channel (CPU memory stage -> unit)
    logic                  req_valid;
    logic                  req_ready;
    logic [1:0]            req_size;
    logic                  req_signed;
    logic [ADDR_WIDTH-1:0] req_addr;

    // Word-addressed memory read channel
    logic                  mem_re;
    logic [ADDR_WIDTH-3:0] mem_addr;
    logic                  mem_rvalid;
    logic [31:0]           mem_rdata;

    // Response channel (unit -> CPU)
    logic                  resp_valid;
    logic                  resp_ready;
    logic [31:0]           resp_data;
    logic                  resp_err;

    modport slave (
        input  req_valid, req_size, req_signed, req_addr,
        input  mem_rvalid, mem_rdata,
        input  resp_ready,
        output req_ready,
        output mem_re, mem_addr,
        output resp_valid, resp_data, resp_err
    );

    modport master (
        output req_valid, req_size, req_signed, req_addr,
        output mem_rvalid, mem_rdata,
        output resp_ready,
        input  req_ready,
        input  mem_re, mem_addr,
        input  resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/load_align_unit.sv
// load_align_unit: sequential big-endian load alignment between the memory
// stage and a variable-latency word-addressed data memory. Issues one or two
// word reads, extracts the addressed byte/half/word and sign/zero-extends it.
// Optional feature macro: MISALIGNED_SPLIT_EN
//   defined   -> misaligned halves/words are serviced (two reads when the
//                access crosses a word boundary)
//   undefined -> misaligned halves/words are rejected with resp_err=1
module load_align_unit #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    load_align_unit_if.slave      bus
);

    localparam int WA = ADDR_WIDTH - 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD0  = 2'd1,
        S_RD1  = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [1:0]      r_size;
    logic            r_signed;
    logic [1:0]      r_off;
    logic            r_split;
    logic [WA-1:0]   r_mem_addr;
    logic [31:0]     r_word_a;
    logic [31:0]     r_resp_data;
    logic            r_resp_err;

    logic            w_accept;
    logic [1:0]      w_off;
    logic            w_err;
    logic            w_split;

    // Select 8/16/32 bits at byte offset 'off' (MSB first) out of {A,B}
    // and extend to 32 bits.
    function automatic logic [31:0] align_extend(
        input logic [63:0] dw,
        input logic [1:0]  off,
        input logic [1:0]  size,
        input logic        sgn
    );
        logic [63:0]        sh;
        logic signed [7:0]  b8;
        logic signed [15:0] h16;
        logic signed [31:0] ext;
        sh  = dw << {off, 3'b000};
        b8  = $signed(sh[63:56]);
        h16 = $signed(sh[63:48]);
        case (size)
            2'b00:   ext = sgn ? 32'(b8)  : $signed({24'h0, sh[63:56]});
            2'b01:   ext = sgn ? 32'(h16) : $signed({16'h0, sh[63:48]});
            default: ext = $signed(sh[63:32]);
        endcase
        return ext;
    endfunction

    assign w_accept = bus.req_valid && (r_state == S_IDLE);
    assign w_off    = bus.req_addr[1:0];

`ifdef MISALIGNED_SPLIT_EN
    // Only an illegal size is rejected; accesses that spill past byte 3 need
    // a second word.
    assign w_err   = (bus.req_size == 2'b11);
    assign w_split = ((bus.req_size == 2'b01) && (w_off == 2'd3)) ||
                     ((bus.req_size == 2'b10) && (w_off != 2'd0));
`else
    // Misaligned halves/words are rejected; single-word reads only.
    assign w_err   = (bus.req_size == 2'b11) ||
                     ((bus.req_size == 2'b01) && w_off[0]) ||
                     ((bus.req_size == 2'b10) && (w_off != 2'd0));
    assign w_split = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_err ? S_RESP : S_RD0;
                end
            end
            S_RD0: begin
                if (bus.mem_rvalid) begin
                    w_state_nxt = r_split ? S_RD1 : S_RESP;
                end
            end
            S_RD1: begin
                if (bus.mem_rvalid) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Request capture, read address sequencing and result formation
    always_ff @(posedge clk) begin
        if (rst) begin
            r_split     <= 1'b0;
            r_mem_addr  <= '0;
            r_resp_data <= '0;
            r_resp_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_size      <= bus.req_size;
                        r_signed    <= bus.req_signed;
                        r_off       <= w_off;
                        r_split     <= w_split;
                        r_mem_addr  <= bus.req_addr[ADDR_WIDTH-1:2];
                        r_resp_err  <= w_err;
                        // Rejected accesses return zero data.
                        r_resp_data <= '0;
                    end
                end
                S_RD0: begin
                    if (bus.mem_rvalid) begin
                        r_word_a <= bus.mem_rdata;
                        if (r_split) begin
                            // Word index wraps naturally at the top of memory.
                            r_mem_addr <= r_mem_addr + WA'(1);
                        end else begin
                            r_resp_data <= align_extend({bus.mem_rdata, 32'h0},
                                                        r_off, r_size, r_signed);
                        end
                    end
                end
                S_RD1: begin
                    if (bus.mem_rvalid) begin
                        r_resp_data <= align_extend({r_word_a, bus.mem_rdata},
                                                    r_off, r_size, r_signed);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.req_ready  = (r_state == S_IDLE);
    assign bus.mem_re     = (r_state == S_RD0) || (r_state == S_RD1);
    assign bus.mem_addr   = r_mem_addr;
    assign bus.resp_valid = (r_state == S_RESP);
    assign bus.resp_data  = r_resp_data;
    assign bus.resp_err   = r_resp_err;

endmodule
